rgb_fade_in: RTL and testbench

- Sequential companion to the combinational RGB divide-by-power-of-two scaler. The scaler dims; this block restores.
- On a start pulse, it dims the pixel stream to 1/2^MAX_SHIFT. It then halves the divisor every FRAMES_PER_STEP frames until the stream passes through at full brightness.
- Sits in the video pipeline between the pixel generator and the VGA output registers, and drives screen fade-in transitions.

---
 rtl/rgb_fade_in.sv | 107 ++++++++++
 tb/tb_rgb_fade_in.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_in.sv
// RGB fade-in controller: on start, dims the pixel stream by 2^MAX_SHIFT and
// halves the divisor every FRAMES_PER_STEP frames until full brightness.
// The pixel path is a one-cycle registered right shift by the current level.
module rgb_fade_in #(
  parameter logic [2:0]  MAX_SHIFT       = 3'd4,  // legal 1..7
  parameter int unsigned FRAMES_PER_STEP = 8      // legal 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       pix_valid_in,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       pix_valid_out,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic [2:0] shift_level,
  output logic       busy,
  output logic       done
);

  // Frame counter only needs to reach FRAMES_PER_STEP-1; keep at least 1 bit.
  localparam int unsigned CntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFading,
    StDone
  } state_e;

  state_e          state;
  logic [CntW-1:0] frame_cnt;

  // Fade sequencer: state, shift level, frame counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      shift_level <= 3'd0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Start (re)launches a fade from any state and beats a same-cycle tick.
        state       <= StFading;
        shift_level <= MAX_SHIFT;
        frame_cnt   <= '0;
        busy        <= 1'b1;
      end else begin
        unique case (state)
          StIdle: begin
            shift_level <= 3'd0;
            busy        <= 1'b0;
          end
          StFading: begin
            if (frame_tick) begin
              if (frame_cnt == CntLast) begin
                frame_cnt   <= '0;
                shift_level <= shift_level - 3'd1;
                if (shift_level == 3'd1) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
          StDone: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
          default: begin
            state       <= StIdle;
            shift_level <= 3'd0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel path: valid always follows input; data loads only on valid pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid_out <= 1'b0;
      r_out         <= 8'h00;
      g_out         <= 8'h00;
      b_out         <= 8'h00;
    end else begin
      pix_valid_out <= pix_valid_in;
      if (pix_valid_in) begin
        r_out <= r_in >> shift_level;
        g_out <= g_in >> shift_level;
        b_out <= b_in >> shift_level;
      end
    end
  end

endmodule

// File: tb/tb_rgb_fade_in.sv
// Directed bench for rgb_fade_in: one instance with MAX_SHIFT=2/FRAMES_PER_STEP=2
// and one with MAX_SHIFT=7/FRAMES_PER_STEP=1, sharing stimulus.
module tb_rgb_fade_in;

  logic       clk = 1'b0;
  logic       reset, start, frame_tick, pix_valid_in;
  logic [7:0] r_in, g_in, b_in;

  logic       a_pvo, a_busy, a_done;
  logic [7:0] a_r, a_g, a_b;
  logic [2:0] a_shift;
  logic       b_pvo, b_busy, b_done;
  logic [7:0] b_r, b_g, b_b;
  logic [2:0] b_shift;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_fade_in #(.MAX_SHIFT(3'd2), .FRAMES_PER_STEP(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .pix_valid_in(pix_valid_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid_out(a_pvo), .r_out(a_r), .g_out(a_g), .b_out(a_b),
    .shift_level(a_shift), .busy(a_busy), .done(a_done)
  );

  rgb_fade_in #(.MAX_SHIFT(3'd7), .FRAMES_PER_STEP(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
    .pix_valid_in(pix_valid_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid_out(b_pvo), .r_out(b_r), .g_out(b_g), .b_out(b_b),
    .shift_level(b_shift), .busy(b_busy), .done(b_done)
  );

  // Advance one clock; sampling and driving happen 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic v, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b);
    pix_valid_in = v;
    r_in = r;
    g_in = g;
    b_in = b;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
    pix(1'b1, 8'h12, 8'h34, 8'h56);
    cyc(); cyc();
    chk("rst_rgb", {8'h0, a_r, a_g, a_b}, 32'h000000);
    chk("rst_pvo", a_pvo, 1'b0);
    chk("rst_shift", a_shift, 3'd0);
    chk("rst_busy_done", {a_busy, a_done}, 2'b00);

    // Pass-through with no start.
    reset = 1'b0;
    pix(1'b1, 8'hFF, 8'hFF, 8'hFF);
    cyc();
    chk("t1_rgb", {8'h0, a_r, a_g, a_b}, 32'hFFFFFF);
    chk("t1_pvo", a_pvo, 1'b1);
    chk("t1_busy", a_busy, 1'b0);
    chk("t1_shift", a_shift, 3'd0);

    // Full fade: shift 2 -> 1 -> 0 with two ticks per step.
    start = 1'b1; pix(1'b0, 8'h00, 8'h00, 8'h00);
    cyc();
    start = 1'b0;
    chk("t2_shift_start", a_shift, 3'd2);
    chk("t2_busy", a_busy, 1'b1);
    pix(1'b1, 8'hFF, 8'h00, 8'hFF);
    cyc();
    chk("t2_rgb_s2", {8'h0, a_r, a_g, a_b}, 32'h3F003F);
    frame_tick = 1'b1;
    cyc();
    chk("t2_shift_tick1", a_shift, 3'd2);
    cyc();
    chk("t2_shift_tick2", a_shift, 3'd1);
    frame_tick = 1'b0;
    cyc();
    chk("t2_rgb_s1", {8'h0, a_r, a_g, a_b}, 32'h7F007F);
    frame_tick = 1'b1;
    cyc();
    chk("t2_done_early", a_done, 1'b0);
    cyc();
    frame_tick = 1'b0;
    chk("t2_done", a_done, 1'b1);
    chk("t2_shift_done", a_shift, 3'd0);
    cyc();
    chk("t2_done_pulse", a_done, 1'b0);
    chk("t2_rgb_s0", {8'h0, a_r, a_g, a_b}, 32'hFF00FF);
    chk("t2_busy_end", a_busy, 1'b0);

    // Restart with a simultaneous tick at shift 1, counter 1.
    start = 1'b1;
    cyc();
    start = 1'b0; frame_tick = 1'b1;
    cyc(); cyc();
    chk("t3_shift1", a_shift, 3'd1);
    cyc();
    chk("t3_shift1_cnt1", a_shift, 3'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t3_restart_shift", a_shift, 3'd2);
    chk("t3_restart_done", a_done, 1'b0);
    cyc();
    chk("t3_cnt_cleared", a_shift, 3'd2);
    chk("t3_no_done", a_done, 1'b0);
    cyc();
    chk("t3_step_after_2", a_shift, 3'd1);
    frame_tick = 1'b0;

    // Reset mid-fade.
    reset = 1'b1;
    cyc();
    chk("t4_shift", a_shift, 3'd0);
    chk("t4_rgb", {8'h0, a_r, a_g, a_b}, 32'h000000);
    chk("t4_pvo", a_pvo, 1'b0);
    chk("t4_busy", a_busy, 1'b0);
    reset = 1'b0;
    pix(1'b1, 8'h80, 8'h40, 8'h20);
    cyc();
    chk("t4_passthru", {8'h0, a_r, a_g, a_b}, 32'h804020);

    // Hold data while pix_valid_in is low.
    pix(1'b1, 8'hAA, 8'hAA, 8'hAA);
    cyc();
    chk("t6_aa", {8'h0, a_r, a_g, a_b}, 32'hAAAAAA);
    pix(1'b0, 8'h55, 8'h55, 8'h55);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_hold", {7'h0, a_pvo, a_r, a_g, a_b}, 32'h0AAAAAA);
    end
    pix(1'b1, 8'h55, 8'h55, 8'h55);
    cyc();
    chk("t6_55", {7'h0, a_pvo, a_r, a_g, a_b}, 32'h1555555);

    // Second instance: MAX_SHIFT=7, one tick per step.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    pix(1'b1, 8'h7F, 8'h80, 8'hFF);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t5_shift7", b_shift, 3'd7);
    cyc();
    chk("t5_rgb_s7", {8'h0, b_r, b_g, b_b}, 32'h000101);
    frame_tick = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("t5_shift_after6", b_shift, 3'd1);
    chk("t5_done_after6", b_done, 1'b0);
    cyc();
    chk("t5_done_after7", b_done, 1'b1);
    chk("t5_shift_done", b_shift, 3'd0);
    cyc();
    chk("t5_tick8_done", b_done, 1'b0);
    chk("t5_tick8_shift", b_shift, 3'd0);
    for (int i = 0; i < 3; i++) cyc();
    chk("t5_idle_ticks", {b_busy, b_shift}, 4'h0);
    frame_tick = 1'b0;
    cyc();
    chk("t5_idle_passthru", {8'h0, b_r, b_g, b_b}, 32'h7F80FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
